xbee_uart_rx: RTL and testbench

//  Parametrised UART receiver for the XBee link. Samples the serial RX line and emits

---
 rtl/xbee_uart_rx.sv | 252 +++++++++++++++++++++++++
 tb/tb_xbee_uart_rx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xbee_uart_rx.sv
// xbee_uart_rx: UART receiver for the XBee serial link.
// Receives start + DATA_BITS (LSB first) [+ parity] + stop frames, emits each good
// byte with a one-cycle data_valid strobe, and flags framing/parity errors.
// It also packs data[0] of CMD_FRAMES consecutive good bytes into cmd_out.
// Optional feature macro: XBEE_RX_PARITY_EN adds a parity bit after the data bits.
// When the macro is undefined, PARITY_ODD is ignored and parity_err is tied to 0.
module xbee_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int CMD_FRAMES   = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RX,
    output logic [DATA_BITS-1:0]  data_out,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic [CMD_FRAMES-1:0] cmd_out,
    output logic                  cmd_valid
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam int IDX_W = (CMD_FRAMES > 1) ? $clog2(CMD_FRAMES) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CMD_FRAMES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef XBEE_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_t;

    // Synchroniser and edge-detect history; preset high so reset release looks idle.
    logic rx_meta_reg;
    logic rxs_reg;
    logic rxs_prev_reg;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      clk_cnt_reg, clk_cnt_next;
    logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0]  shift_reg, shift_next;

    // Per-frame result strobes decided in the sample cycle, registered as outputs.
    logic good_stop;
    logic frame_err_set;
    logic parity_err_set;
    logic parity_bad;

    logic [DATA_BITS-1:0]  data_out_reg;
    logic                  data_valid_reg;
    logic                  frame_err_reg;
    logic                  parity_err_reg;
    logic [CMD_FRAMES-1:0] cmd_shift_reg;
    logic [CMD_FRAMES-1:0] cmd_out_reg;
    logic                  cmd_valid_reg;
    logic [IDX_W-1:0]      cmd_idx_reg;
    logic [CMD_FRAMES-1:0] cmd_word;

`ifdef XBEE_RX_PARITY_EN
    localparam logic PARITY_ODD_BIT = 1'(PARITY_ODD);
    logic parity_bad_reg, parity_bad_next;
    assign parity_bad = parity_bad_reg;
`else
    // Parity is not built in this configuration; the parameter is accepted but unused.
    logic unused_parity_odd;
    assign unused_parity_odd = 1'(PARITY_ODD);
    assign parity_bad        = 1'b0;
`endif

    // Two-flop synchroniser for the asynchronous RX pin plus one stage of history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg  <= 1'b1;
            rxs_reg      <= 1'b1;
            rxs_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg  <= RX;
            rxs_reg      <= rx_meta_reg;
            rxs_prev_reg <= rxs_reg;
        end
    end

    // FSM state and bit-timing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
`ifdef XBEE_RX_PARITY_EN
            parity_bad_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
`ifdef XBEE_RX_PARITY_EN
            parity_bad_reg <= parity_bad_next;
`endif
        end
    end

    // Next-state logic: mid-bit sampling, shifting and per-frame verdict.
    always_comb begin
        state_next     = state_reg;
        clk_cnt_next   = clk_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        good_stop      = 1'b0;
        frame_err_set  = 1'b0;
        parity_err_set = 1'b0;
`ifdef XBEE_RX_PARITY_EN
        parity_bad_next = parity_bad_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (rxs_prev_reg && !rxs_reg) begin
                    state_next   = ST_START;
                    clk_cnt_next = '0;
                    bit_cnt_next = '0;
`ifdef XBEE_RX_PARITY_EN
                    parity_bad_next = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (clk_cnt_reg == HALF_LAST) begin
                    clk_cnt_next = '0;
                    // A start bit that is high again at its centre was a glitch.
                    state_next   = rxs_reg ? ST_IDLE : ST_DATA;
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end
            ST_DATA: begin
                if (clk_cnt_reg == BIT_LAST) begin
                    clk_cnt_next = '0;
                    shift_next   = {rxs_reg, shift_reg[DATA_BITS-1:1]};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == DATA_LAST) begin
`ifdef XBEE_RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end
`ifdef XBEE_RX_PARITY_EN
            ST_PARITY: begin
                if (clk_cnt_reg == BIT_LAST) begin
                    clk_cnt_next    = '0;
                    parity_bad_next = ((^shift_reg) ^ PARITY_ODD_BIT) != rxs_reg;
                    state_next      = ST_STOP;
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (clk_cnt_reg == BIT_LAST) begin
                    clk_cnt_next = '0;
                    if (!rxs_reg) begin
                        frame_err_set  = 1'b1;
                        parity_err_set = parity_bad;
                        state_next     = ST_WAIT_HIGH;
                    end else if (parity_bad) begin
                        parity_err_set = 1'b1;
                        state_next     = ST_IDLE;
                    end else begin
                        good_stop  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low (break) line must go high before a new start is accepted.
                if (rxs_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Command word with the current byte's LSB dropped into its slot.
    generate
        for (genvar gi = 0; gi < CMD_FRAMES; gi++) begin : g_cmd_word
            assign cmd_word[gi] = (cmd_idx_reg == IDX_W'(gi)) ? shift_reg[0]
                                                               : cmd_shift_reg[gi];
        end
    endgenerate

    // Output strobes, byte capture and command-word assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            cmd_shift_reg  <= '0;
            cmd_out_reg    <= '0;
            cmd_valid_reg  <= 1'b0;
            cmd_idx_reg    <= '0;
        end else begin
            data_valid_reg <= good_stop;
            frame_err_reg  <= frame_err_set;
            parity_err_reg <= parity_err_set;
            cmd_valid_reg  <= 1'b0;
            if (good_stop) begin
                data_out_reg  <= shift_reg;
                cmd_shift_reg <= cmd_word;
                if (cmd_idx_reg == IDX_LAST) begin
                    cmd_out_reg   <= cmd_word;
                    cmd_valid_reg <= 1'b1;
                    cmd_idx_reg   <= '0;
                end else begin
                    cmd_idx_reg <= cmd_idx_reg + 1'b1;
                end
            end else if (frame_err_set || parity_err_set) begin
                // Any bad frame discards the partially assembled command.
                cmd_idx_reg <= '0;
            end
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign frame_err  = frame_err_reg;
    assign parity_err = parity_err_reg;
    assign cmd_out    = cmd_out_reg;
    assign cmd_valid  = cmd_valid_reg;

endmodule

// File: tb/tb_xbee_uart_rx.sv
// Testbench for xbee_uart_rx with CLKS_PER_BIT=16, DATA_BITS=8, CMD_FRAMES=8.
// Single frames come from a vector table; command assembly, glitches, reset
// abort and parity (when XBEE_RX_PARITY_EN is defined) are hand-written sequences.
module tb_xbee_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic [7:0] cmd_out;
    logic       cmd_valid;

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse counters maintained by the monitor.
    int dv_cnt  = 0;
    int fe_cnt  = 0;
    int pe_cnt  = 0;
    int cv_cnt  = 0;
    int cv_lone = 0;
    logic [7:0] last_cmd = 8'h00;

    xbee_uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8),
        .CMD_FRAMES  (8),
        .PARITY_ODD  (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (rx),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .cmd_out   (cmd_out),
        .cmd_valid (cmd_valid)
    );

    always #5 clk = ~clk;

    // Count output strobes on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (data_valid) dv_cnt <= dv_cnt + 1;
        if (frame_err)  fe_cnt <= fe_cnt + 1;
        if (parity_err) pe_cnt <= pe_cnt + 1;
        if (cmd_valid) begin
            cv_cnt   <= cv_cnt + 1;
            last_cmd <= cmd_out;
        end
        if (cmd_valid && !data_valid) cv_lone <= cv_lone + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_dv;
        int         exp_fe;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Start bit, data LSB first, correct parity when built in, then the given stop level.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef XBEE_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(1);
    endtask

    initial begin
        int dv0, fe0, cv0, pe0;
        logic [7:0] b2b[8];
        logic [7:0] tail[8];

        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_dv: 1, exp_fe: 0, exp_out: 8'hA5};
        vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_dv: 0, exp_fe: 1, exp_out: 8'hA5};
        vecs[2] = '{data: 8'h11, stop: 1'b1, exp_dv: 1, exp_fe: 0, exp_out: 8'h11};
        vecs[3] = '{data: 8'h00, stop: 1'b1, exp_dv: 1, exp_fe: 0, exp_out: 8'h00};
        vecs[4] = '{data: 8'hFF, stop: 1'b1, exp_dv: 1, exp_fe: 0, exp_out: 8'hFF};
        b2b  = '{8'h31, 8'h30, 8'h31, 8'h31, 8'h30, 8'h30, 8'h30, 8'h31};
        tail = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00};

        // Reset state.
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset data_out",   32'(data_out),   32'h0);
        check("reset data_valid", 32'(data_valid), 32'h0);
        check("reset frame_err",  32'(frame_err),  32'h0);
        check("reset parity_err", 32'(parity_err), 32'h0);
        check("reset cmd_out",    32'(cmd_out),    32'h0);
        check("reset cmd_valid",  32'(cmd_valid),  32'h0);
        $display("reset: data_out=0x%02h cmd_out=0x%02h", data_out, cmd_out);
        rst_n = 1'b1;
        idle_bits(2);

        // Single-frame vectors; a low stop bit is followed by 3 bit-times of break.
        for (int v = 0; v < 5; v++) begin
            dv0 = dv_cnt;
            fe0 = fe_cnt;
            send_frame(vecs[v].data, vecs[v].stop);
            if (!vecs[v].stop) begin
                rx = 1'b0;
                repeat (3 * CPB) @(negedge clk);
            end
            idle_bits(2);
            check($sformatf("vec%0d data_valid count", v), 32'(dv_cnt - dv0), 32'(vecs[v].exp_dv));
            check($sformatf("vec%0d frame_err count", v),  32'(fe_cnt - fe0), 32'(vecs[v].exp_fe));
            check($sformatf("vec%0d data_out", v),         32'(data_out),     32'(vecs[v].exp_out));
            $display("frame 0x%02h stop=%0b: dv=%0d fe=%0d data_out=0x%02h",
                     vecs[v].data, vecs[v].stop, dv_cnt - dv0, fe_cnt - fe0, data_out);
        end

        // Short low glitch: must not start a frame, and the receiver stays usable.
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        rx  = 1'b0;
        repeat (4) @(negedge clk);
        idle_bits(2);
        check("glitch data_valid count", 32'(dv_cnt - dv0), 32'h0);
        check("glitch frame_err count",  32'(fe_cnt - fe0), 32'h0);
        send_frame(8'h96, 1'b1);
        idle_bits(2);
        check("post-glitch data_valid count", 32'(dv_cnt - dv0), 32'h1);
        check("post-glitch data_out",         32'(data_out),     32'h96);
        $display("glitch then 0x96: dv=%0d fe=%0d data_out=0x%02h", dv_cnt - dv0, fe_cnt - fe0, data_out);

        // Eight back-to-back frames assemble one command word.
        pulse_reset();
        dv0 = dv_cnt;
        cv0 = cv_cnt;
        for (int i = 0; i < 8; i++) send_frame(b2b[i], 1'b1);
        idle_bits(2);
        check("b2b data_valid count", 32'(dv_cnt - dv0), 32'h8);
        check("b2b cmd_valid count",  32'(cv_cnt - cv0), 32'h1);
        check("b2b cmd captured",     32'(last_cmd),     32'h8D);
        check("b2b cmd_out",          32'(cmd_out),      32'h8D);
        check("cmd_valid without data_valid", 32'(cv_lone), 32'h0);
        $display("back-to-back x8: dv=%0d cv=%0d cmd_out=0x%02h", dv_cnt - dv0, cv_cnt - cv0, cmd_out);

        // Partial word followed by a framing error must be discarded.
        dv0 = dv_cnt;
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        for (int i = 0; i < 3; i++) begin
            send_frame(8'h01, 1'b1);
            idle_bits(1);
        end
        send_frame(8'h00, 1'b0);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        idle_bits(2);
        for (int i = 0; i < 8; i++) begin
            send_frame(tail[i], 1'b1);
            idle_bits(1);
        end
        idle_bits(1);
        check("partial dv count",  32'(dv_cnt - dv0), 32'd11);
        check("partial fe count",  32'(fe_cnt - fe0), 32'h1);
        check("partial cv count",  32'(cv_cnt - cv0), 32'h1);
        check("partial cmd_out",   32'(cmd_out),      32'h39);
        $display("3 good + err + 8 good: dv=%0d fe=%0d cv=%0d cmd_out=0x%02h",
                 dv_cnt - dv0, fe_cnt - fe0, cv_cnt - cv0, cmd_out);

        // Reset in the middle of the data bits aborts the frame.
        send_frame(8'hC3, 1'b1);
        idle_bits(2);
        check("pre-abort data_out", 32'(data_out), 32'hC3);
        dv0 = dv_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check("abort data_out", 32'(data_out), 32'h0);
        check("abort cmd_out",  32'(cmd_out),  32'h0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(2);
        check("abort no strobe", 32'(dv_cnt - dv0), 32'h0);
        send_frame(8'h5A, 1'b1);
        idle_bits(2);
        check("after abort dv count", 32'(dv_cnt - dv0), 32'h1);
        check("after abort data_out", 32'(data_out),     32'h5A);
        $display("abort then 0x5A: dv=%0d data_out=0x%02h", dv_cnt - dv0, data_out);

`ifdef XBEE_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so a parity bit of 0 is wrong.
        dv0 = dv_cnt;
        pe0 = pe_cnt;
        fe0 = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(i < 3);
        send_bit(1'b0);
        send_bit(1'b1);
        idle_bits(2);
        check("parity err count",   32'(pe_cnt - pe0), 32'h1);
        check("parity no dv",       32'(dv_cnt - dv0), 32'h0);
        check("parity no fe",       32'(fe_cnt - fe0), 32'h0);
        check("parity data_out",    32'(data_out),     32'h5A);
        send_frame(8'h07, 1'b1);
        idle_bits(2);
        check("parity good data_out", 32'(data_out), 32'h07);
        $display("bad parity 0x07: pe=%0d dv=%0d data_out=0x%02h", pe_cnt - pe0, dv_cnt - dv0, data_out);
`else
        pe0 = 0;
        check("parity_err never pulses", 32'(pe_cnt - pe0), 32'h0);
        $display("parity disabled: parity_err pulses=%0d", pe_cnt);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
